refresh_scheduler: RTL and testbench

- Generates and sequences DDR4 auto-refresh requests for the memory controller.
- Tracks the tREFI interval and counts refreshes owed, allowing up to MAXPOSTPONE of them to be postponed.
- Raises a refresh request to the Scheduler: opportunistically when the Scheduler is idle, forcibly (urgent) when the postponement limit is reached.
- Holds off new Scheduler traffic from acceptance of a refresh through completion of tRFC.

---
 rtl/refresh_scheduler_pkg.sv | 17 +
 rtl/refresh_interval_timer.sv | 32 +++
 rtl/refresh_scheduler.sv | 134 +++++++++++++
 tb/tb_refresh_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/refresh_scheduler_pkg.sv
// Shared definitions for the DDR4 refresh scheduler: default timing
// constants and the sequencing state encoding.
package refresh_scheduler_pkg;

  // Default timing, in controller clocks (7.8 us interval at 800 MHz).
  localparam int REF_TREFI       = 6240;
  localparam int REF_TRFC        = 280;
  localparam int REF_MAXPOSTPONE = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    REF_WAIT = 2'd2,
    RFC      = 2'd3
  } refsched_state_t;

endpackage

// File: rtl/refresh_interval_timer.sv
// Reloadable down-counter with enable. tick is high for the cycle in which
// the count sits at zero while enabled; the counter then reloads.
// An explicit load takes priority over counting.
module refresh_interval_timer #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] RELOAD_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  assign tick = en && (count == '0);

  // Count down while enabled, wrap to the reload value at zero, hold otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= (count == '0) ? RELOAD_VALUE : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// DDR4 auto-refresh scheduler. Counts tREFI intervals, tracks refreshes
// owed (postponable up to MAXPOSTPONE), requests refresh from the Scheduler
// and blocks new traffic from acceptance until tRFC has elapsed.
//
// Handshake: refresh is a level request held until ref_ack; ref_ack is a
// one-cycle pulse sampled on the same edge, and refresh falls on the next
// cycle. ref_done is a one-cycle pulse only honoured while waiting for it.
module refresh_scheduler
  import refresh_scheduler_pkg::*;
#(
  parameter int TREFI       = REF_TREFI,
  parameter int TRFC        = REF_TRFC,
  parameter int MAXPOSTPONE = REF_MAXPOSTPONE,
  parameter int CWIDTH_I    = $clog2(TREFI),
  parameter int OWIDTH      = $clog2(MAXPOSTPONE + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              sched_idle,
  input  logic              ref_ack,
  input  logic              ref_done,
  output logic              refresh,
  output logic              ref_urgent,
  output logic              ref_block,
  output logic [OWIDTH-1:0] owed,
  output logic              ref_overflow,
  output logic [1:0]        fsm_state
);

  localparam int                  RWIDTH          = $clog2(TRFC + 1);
  localparam logic [CWIDTH_I-1:0] INTERVAL_RELOAD = CWIDTH_I'(TREFI - 1);
  localparam logic [RWIDTH-1:0]   RFC_LOAD        = RWIDTH'(TRFC - 1);
  localparam logic [OWIDTH-1:0]   OWED_MAX        = OWIDTH'(MAXPOSTPONE);

  refsched_state_t state;
  logic            interval_tick;
  logic            rfc_tick;
  logic            rfc_load;
  logic            rfc_en;
  logic            ack_counts;

  assign ref_urgent = (owed == OWED_MAX);
  assign fsm_state  = state;
  assign rfc_load   = (state == REF_WAIT) && ref_done;
  assign rfc_en     = (state == RFC);
  // An ack with nothing owed cannot lower the count below zero.
  assign ack_counts = ref_ack && (owed != '0);

  refresh_interval_timer #(
    .WIDTH        (CWIDTH_I),
    .RESET_VALUE  (INTERVAL_RELOAD),
    .RELOAD_VALUE (INTERVAL_RELOAD)
  ) u_interval (
    .clock      (clock),
    .reset      (reset),
    .en         (enable),
    .load       (1'b0),
    .load_value ('0),
    .tick       (interval_tick)
  );

  refresh_interval_timer #(
    .WIDTH        (RWIDTH),
    .RESET_VALUE  ('0),
    .RELOAD_VALUE ('0)
  ) u_trfc (
    .clock      (clock),
    .reset      (reset),
    .en         (rfc_en),
    .load       (rfc_load),
    .load_value (RFC_LOAD),
    .tick       (rfc_tick)
  );

  // Owed bookkeeping: ticks add, acks subtract, both together cancel;
  // a tick at saturation latches the overflow error until reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      owed         <= '0;
      ref_overflow <= 1'b0;
    end else if (interval_tick && !ref_ack) begin
      if (owed == OWED_MAX) ref_overflow <= 1'b1;
      else                  owed         <= owed + OWIDTH'(1);
    end else if (!interval_tick && ack_counts) begin
      owed <= owed - OWIDTH'(1);
    end
  end

  // Request/refresh/tRFC sequencing with registered request and block outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      refresh   <= 1'b0;
      ref_block <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if ((owed != '0) && enable && (sched_idle || ref_urgent)) begin
            state   <= REQ;
            refresh <= 1'b1;
          end
        end
        REQ: begin
          // An ack on the same edge as enable dropping still wins: the
          // Scheduler has already issued the refresh.
          if (ref_ack) begin
            state     <= REF_WAIT;
            refresh   <= 1'b0;
            ref_block <= 1'b1;
          end else if (!enable) begin
            state   <= IDLE;
            refresh <= 1'b0;
          end
        end
        REF_WAIT: begin
          if (ref_done) state <= RFC;
        end
        RFC: begin
          if (rfc_tick) begin
            state     <= IDLE;
            ref_block <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          refresh   <= 1'b0;
          ref_block <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Randomized bench for refresh_scheduler with small timing constants.
module tb_refresh_scheduler;

  localparam int TREFI = 16;
  localparam int TRFC  = 4;
  localparam int MAXP  = 3;
  localparam int OW    = 2;
  localparam int W     = 4 + OW;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          sched_idle;
  logic          ref_ack;
  logic          ref_done;
  logic          refresh;
  logic          ref_urgent;
  logic          ref_block;
  logic [OW-1:0] owed;
  logic          ref_overflow;
  logic [1:0]    fsm_state;

  refresh_scheduler #(
    .TREFI       (TREFI),
    .TRFC        (TRFC),
    .MAXPOSTPONE (MAXP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sched_idle   (sched_idle),
    .ref_ack      (ref_ack),
    .ref_done     (ref_done),
    .refresh      (refresh),
    .ref_urgent   (ref_urgent),
    .ref_block    (ref_block),
    .owed         (owed),
    .ref_overflow (ref_overflow),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Interval ticks come from the number of enabled cycles seen; the refresh
  // sequence is tracked as request pending / waiting for done / blocked
  // until an absolute release cycle.
  int m_cyc;
  int m_en_n;
  int m_owed;
  bit m_ovf;
  bit m_req;
  bit m_block;
  bit m_waiting;
  int m_release;

  logic [W-1:0] exp_q[$];

  int n_checks;
  int n_bad;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at cycle %0d", tag, got, exp, m_cyc);
    end
  endtask

  task automatic model_step();
    bit           tick;
    logic [OW-1:0] ow;
    if (!reset) begin
      m_en_n = 0; m_owed = 0; m_ovf = 0;
      m_req = 0; m_block = 0; m_waiting = 0; m_release = 0;
    end else begin
      tick = enable && ((m_en_n % TREFI) == TREFI - 1);
      if (enable) m_en_n++;
      if (m_req) begin
        if (ref_ack) begin
          m_req = 0; m_block = 1; m_waiting = 1;
        end else if (!enable) begin
          m_req = 0;
        end
      end else if (m_waiting) begin
        if (ref_done) begin
          m_waiting = 0;
          m_release = m_cyc + TRFC;
        end
      end else if (m_block) begin
        if (m_cyc == m_release) m_block = 0;
      end else if (m_owed > 0 && enable && (sched_idle || m_owed == MAXP)) begin
        m_req = 1;
      end
      if (tick && !ref_ack) begin
        if (m_owed == MAXP) m_ovf = 1;
        else                m_owed++;
      end else if (!tick && ref_ack && m_owed > 0) begin
        m_owed--;
      end
    end
    m_cyc++;
    ow = m_owed[OW-1:0];
    exp_q.push_back({m_req, m_block, (m_owed == MAXP), m_ovf, ow});
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare();
    logic [W-1:0] e;
    check("queue_depth", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("refresh",      refresh,      e[W-1]);
    check("ref_block",    ref_block,    e[W-2]);
    check("ref_urgent",   ref_urgent,   e[W-3]);
    check("ref_overflow", ref_overflow, e[W-4]);
    check("owed",         owed,         e[OW-1:0]);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
  endtask

  // ---------------- driver ----------------
  // ack_mode: 0 never ack, 1 random ack while requested, 2 ack only on a tick cycle
  task automatic drive(input int p_en, input int p_idle, input int ack_mode,
                       input int p_ack, input int p_done, input int p_spur,
                       input int p_rst);
    bit tick_next;
    reset      = !($urandom_range(999) < p_rst);
    enable     = ($urandom_range(99) < p_en);
    sched_idle = ($urandom_range(99) < p_idle);
    tick_next  = enable && ((m_en_n % TREFI) == TREFI - 1);
    ref_ack    = 1'b0;
    if (m_req && m_owed > 0) begin
      case (ack_mode)
        1:       ref_ack = ($urandom_range(99) < p_ack);
        2:       ref_ack = tick_next;
        default: ref_ack = 1'b0;
      endcase
    end else if (!m_req && m_owed > 0 && ack_mode != 0) begin
      ref_ack = ($urandom_range(99) < p_spur);
    end
    if (m_waiting) ref_done = ($urandom_range(99) < p_done);
    else           ref_done = ($urandom_range(99) < p_spur);
    assert (!(ref_ack && m_owed == 0));
  endtask

  task automatic run_phase(input int n, input int p_en, input int p_idle,
                           input int ack_mode, input int p_ack, input int p_done,
                           input int p_spur, input int p_rst);
    for (int i = 0; i < n; i++) begin
      drive(p_en, p_idle, ack_mode, p_ack, p_done, p_spur, p_rst);
      cycle();
    end
  endtask

  task automatic apply_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0; enable = 1'b1; sched_idle = 1'b1;
      ref_ack = 1'b0; ref_done = 1'b0;
      cycle();
    end
    check("state_after_reset", fsm_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0; n_bad = 0;
    m_cyc = 0; m_en_n = 0; m_owed = 0; m_ovf = 0;
    m_req = 0; m_block = 0; m_waiting = 0; m_release = 0;
    reset = 1'b0; enable = 1'b0; sched_idle = 1'b0;
    ref_ack = 1'b0; ref_done = 1'b0;

    apply_reset(3);
    // idle scheduler, prompt acks: normal refresh cadence
    run_phase(300, 100, 100, 1, 40, 30, 0, 0);
    // busy scheduler, no acks: owed saturates, urgent, then overflow
    run_phase(120, 100, 0, 0, 0, 0, 0, 0);
    // acks resume: overflow must stay latched
    run_phase(200, 100, 50, 1, 40, 40, 0, 0);
    apply_reset(2);
    // acks only on tick cycles: tick and ack cancel in owed
    run_phase(300, 100, 100, 2, 0, 50, 0, 0);
    // enable toggling, spurious acks/dones, occasional resets mid-sequence
    run_phase(1500, 70, 60, 1, 30, 40, 3, 4);
    apply_reset(1);
    run_phase(200, 90, 80, 1, 50, 50, 2, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
